// File: rtl/register_file_pkg.sv
// register_file_pkg: shared sizing constants and instruction-class codes for the rename register file.
package register_file_pkg;
  localparam int ROB_WIDTH_DEFAULT = 4;
  localparam int REG_COUNT = 32;
  typedef enum logic [1:0] {
    REG_INSTR    = 2'd0,
    STORE_INSTR  = 2'd1,
    BRANCH_INSTR = 2'd2,
    JALR_INSTR   = 2'd3
  } instr_class_e;
endpackage

// File: rtl/rf_read_port.sv
// rf_read_port: combinational operand lookup with optional same-cycle commit bypass.
// Bypass is compiled in when RF_COMMIT_BYPASS_EN is defined.
module rf_read_port
  import register_file_pkg::*;
#(
  parameter int ROB_WIDTH = ROB_WIDTH_DEFAULT
) (
  input  logic [4:0]                           rs_id,
  input  logic [REG_COUNT-1:0][31:0]           values,
  input  logic [REG_COUNT-1:0]                 busy,
  input  logic [REG_COUNT-1:0][ROB_WIDTH-1:0]  tags,
  input  logic                                 reg_done,
  input  logic [31:0]                          reg_value,
  input  logic [4:0]                           reg_id,
  input  logic [ROB_WIDTH-1:0]                 reg_tag,
  output logic [31:0]                          rs_value,
  output logic                                 rs_busy,
  output logic [ROB_WIDTH-1:0]                 rs_tag
);
  logic hit;
  logic zero;
  assign zero = rs_id == 5'd0;
`ifdef RF_COMMIT_BYPASS_EN
  assign hit = reg_done && !zero && rs_id == reg_id && busy[rs_id] && tags[rs_id] == reg_tag;
`else
  logic unused_commit;
  assign unused_commit = ^{reg_done, reg_value, reg_id, reg_tag};
  assign hit = 1'b0;
`endif
  always_comb begin
    rs_value = zero ? 32'd0 : hit ? reg_value : values[rs_id];
    rs_busy  = !zero && busy[rs_id] && !hit;
    rs_tag   = zero ? '0 : tags[rs_id];
  end
endmodule

// File: rtl/register_file.sv
// register_file: 32-entry architectural register file with ROB rename tags and flush.
// Optional same-cycle commit bypass on the read ports via RF_COMMIT_BYPASS_EN.
module register_file
  import register_file_pkg::*;
#(
  parameter int ROB_WIDTH = ROB_WIDTH_DEFAULT
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 clear_signal,
  input  logic                 issue_signal,
  input  logic [4:0]           issue_rd_id,
  input  logic [ROB_WIDTH-1:0] issue_tag,
  input  logic                 reg_done,
  input  logic [31:0]          reg_value,
  input  logic [4:0]           reg_id,
  input  logic [ROB_WIDTH-1:0] reg_tag,
  input  logic [4:0]           rs1_id,
  input  logic [4:0]           rs2_id,
  output logic [31:0]          rs1_value,
  output logic [31:0]          rs2_value,
  output logic                 rs1_busy,
  output logic                 rs2_busy,
  output logic [ROB_WIDTH-1:0] rs1_tag,
  output logic [ROB_WIDTH-1:0] rs2_tag
);
  logic [REG_COUNT-1:0][31:0]          vals;
  logic [REG_COUNT-1:0]                busy;
  logic [REG_COUNT-1:0][ROB_WIDTH-1:0] tags;
  logic commit;
  logic issue;
  assign commit = reg_done && reg_id != 5'd0;
  assign issue  = issue_signal && issue_rd_id != 5'd0;
  // Entry 0 is never written, so x0 stays at its reset value of zero.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      vals <= '0;
      busy <= '0;
      tags <= '0;
    end else if (rdy_in) begin
      for (int i = 1; i < REG_COUNT; i++) begin
        if (commit && reg_id == 5'(i)) vals[i] <= reg_value;
        if (clear_signal) busy[i] <= 1'b0;
        else if (issue && issue_rd_id == 5'(i)) begin
          busy[i] <= 1'b1;
          tags[i] <= issue_tag;
        end else if (commit && reg_id == 5'(i) && tags[i] == reg_tag) busy[i] <= 1'b0;
      end
    end
  end
  rf_read_port #(.ROB_WIDTH(ROB_WIDTH)) u_rs1 (
    .rs_id(rs1_id), .values(vals), .busy(busy), .tags(tags),
    .reg_done(reg_done), .reg_value(reg_value), .reg_id(reg_id), .reg_tag(reg_tag),
    .rs_value(rs1_value), .rs_busy(rs1_busy), .rs_tag(rs1_tag)
  );
  rf_read_port #(.ROB_WIDTH(ROB_WIDTH)) u_rs2 (
    .rs_id(rs2_id), .values(vals), .busy(busy), .tags(tags),
    .reg_done(reg_done), .reg_value(reg_value), .reg_id(reg_id), .reg_tag(reg_tag),
    .rs_value(rs2_value), .rs_busy(rs2_busy), .rs_tag(rs2_tag)
  );
endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 SHALL have parameter ROB_WIDTH, default 4, meaning the ROB tag width (ROB depth 2**ROB_WIDTH).
REQ-002 SHALL have port clk_in, input, 1, system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_in, input, 1, reset; asynchronous and active-low.
REQ-004 SHALL have port rdy_in, input, 1, pause; when low, state is held.
REQ-005 SHALL have port clear_signal, input, 1, misprediction flush from ROB.
REQ-006 SHALL have ports issue_signal (1), issue_rd_id (5) and issue_tag (ROB_WIDTH), all inputs: rename rd to the new ROB entry.
REQ-007 SHALL have ports reg_done (1), reg_value (32), reg_id (5) and reg_tag (ROB_WIDTH), all inputs: ROB commit.
REQ-008 SHALL have ports rs1_id and rs2_id, input, 5 each: combinational read addresses.
REQ-009 SHALL have ports rs1_value and rs2_value, output, 32 each: architectural value, or bypassed commit value.
REQ-010 SHALL have ports rs1_busy and rs2_busy, output, 1 each: 1 means the operand waits on a ROB tag.
REQ-011 SHALL have ports rs1_tag and rs2_tag, output, ROB_WIDTH each: pending producer tag, meaningful only when busy.

Function
REQ-012 SHALL hold 32 entries, each with value[31:0], busy and tag[ROB_WIDTH-1:0].
REQ-013 Register x0 SHALL always read value 0 and busy 0; writes and renames to id 0 are ignored.
REQ-014 Commit SHALL occur when rdy_in & reg_done & reg_id!=0: value[reg_id]<=reg_value, taking effect the next cycle.
REQ-015 On commit, busy[reg_id] SHALL clear only if busy & tag[reg_id]==reg_tag; an older commit never clears a younger rename.
REQ-016 Issue SHALL occur when rdy_in & issue_signal & ~clear_signal & issue_rd_id!=0: busy<=1, tag<=issue_tag.
REQ-017 When issue and commit hit the same rd in one cycle, the value SHALL be written, busy SHALL stay 1 and tag SHALL take issue_tag (issue wins).
REQ-018 When rdy_in & clear_signal, all busy bits SHALL clear and any issue that cycle SHALL be dropped.
REQ-019 When rdy_in & clear_signal, a same-cycle commit (e.g. JALR link) SHALL still write its value.
REQ-020 Read ports SHALL be combinational, with zero-cycle latency from rsX_id.
REQ-021 Tags SHALL be compared at ROB_WIDTH bits with no wrap handling; uniqueness is guaranteed by the ROB.
REQ-022 While rdy_in is low, no state SHALL change; read ports keep reflecting current state.

Reset
REQ-023 On rst_in low, asynchronously: all values 0, all busy 0, all tags 0.
REQ-024 Outputs SHALL follow the reset state: rsX_value 0, rsX_busy 0, rsX_tag 0.
REQ-025 Reset released mid-operation SHALL leave no pending rename.

Configuration
REQ-026 Macro RF_COMMIT_BYPASS_EN defined: if reg_done & reg_id==rsX_id!=0 & busy & tag==reg_tag, the port SHALL output busy=0 and value=reg_value in the same cycle.
REQ-027 Macro RF_COMMIT_BYPASS_EN undefined: read ports SHALL reflect registered state only; the operand becomes ready one cycle after commit.

Structure
REQ-028 A shared package/header SHALL hold ROB_WIDTH default, REG_COUNT=32, and the instruction-class codes REG_INSTR/STORE_INSTR/BRANCH_INSTR/JALR_INSTR.
REQ-029 One sub-module, rf_read_port (lookup plus optional bypass), SHALL be instantiated twice (rs1, rs2).

Verification
REQ-030 Reset, then read x5 -> value 0, busy 0; issue rd=5 tag=3 -> next cycle busy 1, tag 3.
REQ-031 x5 busy tag 3; commit id=5 tag=3 value 0xDEADBEEF -> next cycle value 0xDEADBEEF, busy 0; with RF_COMMIT_BYPASS_EN, same cycle ready.
REQ-032 x7 renamed tag 2 then tag 6; commit id=7 tag=2 value 0x11 -> value 0x11, busy stays 1, tag 6.
REQ-033 Same cycle: issue rd=9 tag=4 plus commit id=9 tag=1 value 0x22 -> value 0x22, busy 1, tag 4.
REQ-034 x3, x4 busy; clear_signal with commit id=1 value 0x1004 and issue rd=8 -> x1=0x1004, all busy 0, x8 not renamed.
REQ-035 Issue rd=0 and commit id=0 value 0xFF -> x0 reads 0, busy 0; rdy_in low with commit pending -> no change.
